// File: rtl/ipv4_fib_lpm_lut.sv
// ipv4_fib_lpm_lut: longest-prefix-match FIB table scanned ROWS_PER_CYCLE rows per cycle.
module ipv4_fib_lpm_lut #(
  parameter int FIB_ROWS       = 32,
  parameter int FIB_ROW_BITS   = 5,
  parameter int ROWS_PER_CYCLE = 8,
  parameter int OIF_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_wr_req,
  output logic                    o_wr_ack,
  input  logic [FIB_ROW_BITS-1:0] i_wr_addr,
  input  logic                    i_wr_valid,
  input  logic [31:0]             i_wr_oif,
  input  logic [31:0]             i_wr_nh,
  input  logic [31:0]             i_wr_mask,
  input  logic [31:0]             i_wr_net,
  input  logic                    i_rd_req,
  output logic                    o_rd_ack,
  input  logic [FIB_ROW_BITS-1:0] i_rd_addr,
  output logic                    o_rd_valid,
  output logic [OIF_WIDTH-1:0]    o_rd_oif,
  output logic [31:0]             o_rd_nh,
  output logic [31:0]             o_rd_mask,
  output logic [31:0]             o_rd_net,
  input  logic [31:0]             i_lkup_daddr,
  input  logic                    i_lkup_valid,
  output logic                    o_lkup_ready,
  output logic                    o_res_valid,
  output logic                    o_res_found,
  output logic [31:0]             o_res_nh,
  output logic [OIF_WIDTH-1:0]    o_res_oif,
  output logic [FIB_ROW_BITS-1:0] o_res_row
);
  localparam int SCAN_CYCLES = FIB_ROWS / ROWS_PER_CYCLE;
  localparam logic [FIB_ROW_BITS-1:0] STEP = FIB_ROW_BITS'(ROWS_PER_CYCLE);
  localparam logic [FIB_ROW_BITS-1:0] LAST = FIB_ROW_BITS'((SCAN_CYCLES - 1) * ROWS_PER_CYCLE);
  typedef enum logic {IDLE, SCAN} state_t;
  typedef struct packed {
    logic                 v;
    logic [OIF_WIDTH-1:0] oif;
    logic [31:0]          nh;
    logic [31:0]          mask;
    logic [31:0]          net;
  } row_t;
  typedef struct packed {
    logic                    found;
    logic [FIB_ROW_BITS-1:0] row;
    logic [31:0]             nh;
    logic [OIF_WIDTH-1:0]    oif;
  } res_t;
  row_t tbl_q [FIB_ROWS];
  row_t tbl_d [FIB_ROWS];
  row_t rd_q, rd_d;
  res_t best_q, best_d, res_q, res_d;
  state_t state_q, state_d;
  logic [FIB_ROW_BITS-1:0] base_q, base_d, row_idx;
  logic [31:0] daddr_q, daddr_d, bmask_q, bmask_d;
  logic res_valid_q, res_valid_d, rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, rd_go, wr_go;
  logic unused_oif;
  assign unused_oif = ^i_wr_oif;
  always_comb begin
    tbl_d       = tbl_q;
    rd_d        = rd_q;
    best_d      = best_q;
    bmask_d     = bmask_q;
    res_d       = res_q;
    state_d     = state_q;
    base_d      = base_q;
    daddr_d     = daddr_q;
    res_valid_d = 1'b0;
    row_idx     = '0;
    rd_go       = i_rd_req && !rd_ack_q;
    wr_go       = i_wr_req && !wr_ack_q && !rd_go && state_q == IDLE;
    rd_ack_d    = rd_go;
    wr_ack_d    = wr_go;
    if (rd_go) rd_d = tbl_q[i_rd_addr];
    if (wr_go) tbl_d[i_wr_addr] = '{i_wr_valid, i_wr_oif[OIF_WIDTH-1:0], i_wr_nh, i_wr_mask, i_wr_net};
    if (state_q == IDLE) begin
      if (i_lkup_valid) begin
        state_d = SCAN;
        daddr_d = i_lkup_daddr;
        best_d  = '0;
        bmask_d = '0;
        base_d  = '0;
      end
    end else begin
      // ascending row order with a strict compare keeps the lowest index on equal masks
      for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
        row_idx = base_q + FIB_ROW_BITS'(j);
        if (tbl_q[row_idx].v && ((daddr_q ^ tbl_q[row_idx].net) & tbl_q[row_idx].mask) == '0 &&
            (!best_d.found || tbl_q[row_idx].mask > bmask_d)) begin
          best_d  = '{1'b1, row_idx, tbl_q[row_idx].nh, tbl_q[row_idx].oif};
          bmask_d = tbl_q[row_idx].mask;
        end
      end
      base_d = base_q + STEP;
      if (base_q == LAST) begin
        state_d     = IDLE;
        res_valid_d = 1'b1;
        res_d       = best_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tbl_q       <= '{default: '0};
      rd_q        <= '0;
      best_q      <= '0;
      bmask_q     <= '0;
      res_q       <= '0;
      state_q     <= IDLE;
      base_q      <= '0;
      daddr_q     <= '0;
      res_valid_q <= 1'b0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      tbl_q       <= tbl_d;
      rd_q        <= rd_d;
      best_q      <= best_d;
      bmask_q     <= bmask_d;
      res_q       <= res_d;
      state_q     <= state_d;
      base_q      <= base_d;
      daddr_q     <= daddr_d;
      res_valid_q <= res_valid_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
    end
  end
  assign o_lkup_ready = state_q == IDLE;
  assign o_res_valid  = res_valid_q;
  assign o_res_found  = res_q.found;
  assign o_res_nh     = res_q.nh;
  assign o_res_oif    = res_q.oif;
  assign o_res_row    = res_q.row;
  assign o_rd_ack     = rd_ack_q;
  assign o_wr_ack     = wr_ack_q;
  assign o_rd_valid   = rd_q.v;
  assign o_rd_oif     = rd_q.oif;
  assign o_rd_nh      = rd_q.nh;
  assign o_rd_mask    = rd_q.mask;
  assign o_rd_net     = rd_q.net;
endmodule

// File: tb/tb_ipv4_fib_lpm_lut.sv
// tb_ipv4_fib_lpm_lut: scoreboard bench with a prefix-match reference model of the FIB.
module tb_ipv4_fib_lpm_lut;
  localparam int N = 32;
  localparam int LAT = 5;
  logic clk = 0, resetn = 0;
  logic i_wr_req = 0, i_wr_valid = 0, i_rd_req = 0, i_lkup_valid = 0;
  logic [4:0] i_wr_addr = 0, i_rd_addr = 0;
  logic [31:0] i_wr_oif = 0, i_wr_nh = 0, i_wr_mask = 0, i_wr_net = 0, i_lkup_daddr = 0;
  logic o_wr_ack, o_rd_ack, o_rd_valid, o_lkup_ready, o_res_valid, o_res_found;
  logic [7:0] o_rd_oif, o_res_oif;
  logic [31:0] o_rd_nh, o_rd_mask, o_rd_net, o_res_nh;
  logic [4:0] o_res_row;

  ipv4_fib_lpm_lut dut (
    .clk(clk), .resetn(resetn),
    .i_wr_req(i_wr_req), .o_wr_ack(o_wr_ack), .i_wr_addr(i_wr_addr), .i_wr_valid(i_wr_valid),
    .i_wr_oif(i_wr_oif), .i_wr_nh(i_wr_nh), .i_wr_mask(i_wr_mask), .i_wr_net(i_wr_net),
    .i_rd_req(i_rd_req), .o_rd_ack(o_rd_ack), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid),
    .o_rd_oif(o_rd_oif), .o_rd_nh(o_rd_nh), .o_rd_mask(o_rd_mask), .o_rd_net(o_rd_net),
    .i_lkup_daddr(i_lkup_daddr), .i_lkup_valid(i_lkup_valid), .o_lkup_ready(o_lkup_ready),
    .o_res_valid(o_res_valid), .o_res_found(o_res_found), .o_res_nh(o_res_nh),
    .o_res_oif(o_res_oif), .o_res_row(o_res_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic found; logic [31:0] nh; logic [7:0] oif; logic [4:0] row; int cyc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  logic m_v [N];
  logic [7:0] m_oif [N];
  logic [31:0] m_nh [N], m_mask [N], m_net [N];

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < N; r++) begin
      m_v[r] = 0; m_oif[r] = 0; m_nh[r] = 0; m_mask[r] = 0; m_net[r] = 0;
    end
  endfunction

  // longest prefix = numerically largest mask among matches, then the lowest row holding it
  function automatic exp_t ref_lookup(logic [31:0] a);
    exp_t e;
    int hits[$];
    logic [31:0] top = 0;
    e = '{0, 0, 0, 0, 0};
    for (int r = 0; r < N; r++)
      if (m_v[r] && (a & m_mask[r]) == (m_net[r] & m_mask[r])) hits.push_back(r);
    foreach (hits[i]) if (m_mask[hits[i]] > top) top = m_mask[hits[i]];
    foreach (hits[i])
      if (!e.found && m_mask[hits[i]] == top) begin
        e.found = 1; e.row = 5'(hits[i]); e.nh = m_nh[hits[i]]; e.oif = m_oif[hits[i]];
      end
    return e;
  endfunction

  always @(negedge clk) begin
    if (o_res_valid) begin
      if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_cycle", 64'(cyc), 64'(e.cyc));
        chk("res_found", 64'(o_res_found), 64'(e.found));
        chk("res_nh", 64'(o_res_nh), 64'(e.nh));
        chk("res_oif", 64'(o_res_oif), 64'(e.oif));
        chk("res_row", 64'(o_res_row), 64'(e.row));
      end
    end
  end

  task automatic do_write(input logic [4:0] a, input logic v, input logic [7:0] oif,
                          input logic [31:0] nh, input logic [31:0] mask, input logic [31:0] net,
                          output int ack_cyc);
    int n = 0;
    i_wr_addr = a; i_wr_valid = v; i_wr_oif = {24'hABCDEF, oif};
    i_wr_nh = nh; i_wr_mask = mask; i_wr_net = net; i_wr_req = 1;
    do begin @(negedge clk); n++; end while (!o_wr_ack && n < 60);
    i_wr_req = 0;
    ack_cyc = cyc;
    if (!o_wr_ack) chk("wr_ack_timeout", 0, 1);
    m_v[a] = v; m_oif[a] = oif; m_nh[a] = nh; m_mask[a] = mask; m_net[a] = net;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] oif, input logic [31:0] mask,
                    input logic [31:0] net);
    int c;
    do_write(a, 1, oif, 32'hC0A80000 + 32'(a), mask, net, c);
  endtask

  task automatic do_read(input logic [4:0] a);
    int n = 0;
    i_rd_addr = a; i_rd_req = 1;
    do begin @(negedge clk); n++; end while (!o_rd_ack && n < 10);
    i_rd_req = 0;
    chk("rd_ack", 64'(o_rd_ack), 1);
    chk("rd_valid", 64'(o_rd_valid), 64'(m_v[a]));
    chk("rd_oif", 64'(o_rd_oif), 64'(m_oif[a]));
    chk("rd_nh", 64'(o_rd_nh), 64'(m_nh[a]));
    chk("rd_mask", 64'(o_rd_mask), 64'(m_mask[a]));
    chk("rd_net", 64'(o_rd_net), 64'(m_net[a]));
  endtask

  task automatic lookup(input logic [31:0] a, output int acc_cyc);
    exp_t e;
    int n = 0;
    while (!o_lkup_ready && n < 60) begin @(negedge clk); n++; end
    if (!o_lkup_ready) chk("lkup_ready_timeout", 0, 1);
    i_lkup_valid = 1; i_lkup_daddr = a;
    e = ref_lookup(a);
    e.cyc = cyc + LAT;
    acc_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    i_lkup_valid = 0;
  endtask

  task automatic lk(input logic [31:0] a);
    int c;
    lookup(a, c);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin chk("drain_timeout", 64'(sb.size()), 0); sb.delete(); end
  endtask

  function automatic logic [31:0] pmask(int len);
    return len == 0 ? 32'h0 : 32'hFFFFFFFF << (32 - len);
  endfunction

  initial begin
    int t, ack_c;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("rst_lkup_ready", 64'(o_lkup_ready), 1);
    chk("rst_res_valid", 64'(o_res_valid), 0);
    chk("rst_wr_ack", 64'(o_wr_ack), 0);
    chk("rst_rd_ack", 64'(o_rd_ack), 0);
    chk("rst_res_found", 64'(o_res_found), 0);
    do_read(5'd7);
    lk(32'h0A010203);
    drain();
    wr(5'd0, 8'd1, pmask(8), 32'h0A000000);
    wr(5'd5, 8'd2, pmask(16), 32'h0A010000);
    wr(5'd31, 8'd4, pmask(0), 32'h00000000);
    lk(32'h0A010203);
    lk(32'hC0A80101);
    lk(32'h0A020304);
    drain();
    do_read(5'd5);
    do_read(5'd31);
    wr(5'd3, 8'd7, pmask(8), 32'h0A000000);
    wr(5'd9, 8'd9, pmask(8), 32'h0A000000);
    lk(32'h0A7F0001);
    drain();
    // write arriving mid-scan must wait for IDLE and leave this lookup on the old row 5
    lookup(32'h0A010203, t);
    @(negedge clk);
    do_write(5'd5, 1, 8'd6, 32'h11111111, pmask(24), 32'h0A010200, ack_c);
    chk("wr_ack_not_before_T6", 64'(ack_c >= t + 6), 1);
    drain();
    lk(32'h0A010203);
    drain();
    // write and lookup accepted together: lookup sees the new row
    while (!o_lkup_ready) @(negedge clk);
    i_wr_addr = 5'd12; i_wr_valid = 1; i_wr_oif = 32'h33; i_wr_nh = 32'h12121212;
    i_wr_mask = 32'hFFFFFFFF; i_wr_net = 32'h0A010203; i_wr_req = 1;
    m_v[12] = 1; m_oif[12] = 8'h33; m_nh[12] = 32'h12121212; m_mask[12] = 32'hFFFFFFFF;
    m_net[12] = 32'h0A010203;
    lk(32'h0A010203);
    chk("same_cycle_wr_ack", 64'(o_wr_ack), 1);
    i_wr_req = 0;
    drain();
    // reset mid-scan: no result for the abandoned lookup, table cleared
    lookup(32'h0A010203, t);
    @(negedge clk);
    resetn = 0;
    sb.delete();
    model_clear();
    @(negedge clk);
    resetn = 1;
    chk("post_rst_ready", 64'(o_lkup_ready), 1);
    repeat (8) @(negedge clk);
    do_read(5'd5);
    lk(32'h0A010203);
    drain();
    for (int round = 0; round < 8; round++) begin
      for (int w = 0; w < 16; w++) begin
        int len;
        logic [31:0] net;
        len = $urandom_range(0, 32);
        net = {8'd10, 8'($urandom_range(0, 3)), 16'($urandom)};
        do_write(5'($urandom_range(0, 31)), $urandom_range(0, 9) != 0, 8'($urandom),
                 $urandom, pmask(len), net, ack_c);
      end
      for (int l = 0; l < 10; l++)
        lk({($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'd10, 8'($urandom_range(0, 3)), 16'($urandom)});
      drain();
      do_read(5'($urandom_range(0, 31)));
    end
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
